// File: rtl/if_align_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | if_align_stage                                                         |
// | IF stage: fetch address generation, 16/32-bit realignment through a    |
// | one-halfword carry buffer, and IF/ID register. Optional performance    |
// | counters under macro IF_PERF_CNT_EN.                                   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module if_align_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        if_stall,
  input  logic        jump,
  input  logic [31:0] new_pc,
  output logic        ic_ren,
  output logic [29:0] ic_addr,
  input  logic [31:0] ic_rdata,
  input  logic        ic_stall,
  output logic [31:0] ins,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic        is_c,
  output logic        ins_valid,
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_flushes
);

  logic [15:0] hbuf_q, hbuf_d;
  logic        hvalid_q, hvalid_d;
  logic [31:0] spc_q, spc_d;
  logic [29:0] fpc_q, fpc_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_4_q, pc_4_d;
  logic        is_c_q, is_c_d;
  logic        ins_valid_q, ins_valid_d;

  logic        hbuf_c;
  logic        word_acc;
  logic        issue;
  logic [31:0] iss_ins;
  logic        iss_c;
  logic [31:0] iss_step;

  // A compressed instruction already in the buffer needs no new word.
  assign hbuf_c   = (hbuf_q[1:0] != 2'b11);
  assign ic_ren   = rst_n & ~(hvalid_q & hbuf_c);
  assign ic_addr  = fpc_q;
  assign word_acc = ic_ren & ~ic_stall & ~stall & ~if_stall & ~jump;

  always_comb begin
    hbuf_d      = hbuf_q;
    hvalid_d    = hvalid_q;
    spc_d       = spc_q;
    fpc_d       = fpc_q;
    ins_d       = ins_q;
    pc_d        = pc_q;
    pc_4_d      = pc_4_q;
    is_c_d      = is_c_q;
    ins_valid_d = ins_valid_q;
    issue       = 1'b0;
    iss_ins     = NOP;
    iss_c       = 1'b0;
    iss_step    = 32'd4;

    if (stall) begin
      // Global hold; a concurrent jump is re-presented by ID later.
    end else if (jump) begin
      ins_d       = NOP;
      ins_valid_d = 1'b0;
      is_c_d      = 1'b0;
      hvalid_d    = 1'b0;
      spc_d       = new_pc & 32'hFFFF_FFFE;
      fpc_d       = new_pc[31:2];
    end else if (!if_stall) begin
      if (hvalid_q && hbuf_c) begin
        issue    = 1'b1;
        iss_ins  = {16'h0000, hbuf_q};
        hvalid_d = 1'b0;
      end else if (hvalid_q && word_acc) begin
        issue   = 1'b1;
        iss_ins = {ic_rdata[15:0], hbuf_q};
        hbuf_d  = ic_rdata[31:16];
        fpc_d   = fpc_q + 30'd1;
      end else if (word_acc && !spc_q[1]) begin
        issue = 1'b1;
        fpc_d = fpc_q + 30'd1;
        if (ic_rdata[1:0] != 2'b11) begin
          iss_ins  = {16'h0000, ic_rdata[15:0]};
          hbuf_d   = ic_rdata[31:16];
          hvalid_d = 1'b1;
        end else begin
          iss_ins = ic_rdata;
        end
      end else if (word_acc) begin
        // Halfword-aligned target: the lower half of the word is not ours.
        fpc_d = fpc_q + 30'd1;
        if (ic_rdata[17:16] != 2'b11) begin
          issue   = 1'b1;
          iss_ins = {16'h0000, ic_rdata[31:16]};
        end else begin
          hbuf_d   = ic_rdata[31:16];
          hvalid_d = 1'b1;
        end
      end

      iss_c    = (iss_ins[1:0] != 2'b11);
      iss_step = iss_c ? 32'd2 : 32'd4;

      if (issue) begin
        ins_d       = iss_ins;
        pc_d        = spc_q;
        pc_4_d      = spc_q + iss_step;
        spc_d       = spc_q + iss_step;
        is_c_d      = iss_c;
        ins_valid_d = 1'b1;
      end else begin
        ins_d       = NOP;
        ins_valid_d = 1'b0;
        is_c_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hbuf_q      <= 16'h0000;
      hvalid_q    <= 1'b0;
      spc_q       <= RESET_PC & 32'hFFFF_FFFE;
      fpc_q       <= RESET_PC[31:2];
      ins_q       <= NOP;
      pc_q        <= 32'h0000_0000;
      pc_4_q      <= 32'h0000_0000;
      is_c_q      <= 1'b0;
      ins_valid_q <= 1'b0;
    end else begin
      hbuf_q      <= hbuf_d;
      hvalid_q    <= hvalid_d;
      spc_q       <= spc_d;
      fpc_q       <= fpc_d;
      ins_q       <= ins_d;
      pc_q        <= pc_d;
      pc_4_q      <= pc_4_d;
      is_c_q      <= is_c_d;
      ins_valid_q <= ins_valid_d;
    end
  end

  assign ins       = ins_q;
  assign pc        = pc_q;
  assign pc_4      = pc_4_q;
  assign is_c      = is_c_q;
  assign ins_valid = ins_valid_q;

`ifdef IF_PERF_CNT_EN
  logic        bubble_evt;
  logic        flush_evt;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;
  logic [31:0] perf_flushes_q, perf_flushes_d;

  // Holds and flushes are not counted as bubbles.
  assign bubble_evt = ~stall & ~jump & ~if_stall & ~issue;
  assign flush_evt  = ~stall & jump;

  always_comb begin
    perf_bubbles_d = perf_bubbles_q;
    perf_flushes_d = perf_flushes_q;
    if (bubble_evt && (perf_bubbles_q != 32'hFFFF_FFFF))
      perf_bubbles_d = perf_bubbles_q + 32'd1;
    if (flush_evt && (perf_flushes_q != 32'hFFFF_FFFF))
      perf_flushes_d = perf_flushes_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_bubbles_q <= 32'h0000_0000;
      perf_flushes_q <= 32'h0000_0000;
    end else begin
      perf_bubbles_q <= perf_bubbles_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_flushes = perf_flushes_q;
`else
  assign perf_bubbles = 32'h0000_0000;
  assign perf_flushes = 32'h0000_0000;
`endif

endmodule
`default_nettype wire
